vram_port_arbiter: RTL and testbench

- Shares one 32-bit simple-dual-port video RAM between three agents: the display scan reader, CPU reads, and CPU writes.
- Also contains a hardware fill engine that clears or fills a RAM region.
- Sits between the bus/CPU interface, the video scanner, and the RAM instance.
- Owns sequencing of both RAM ports, the 2-cycle read-latency return routing, and CPU read-after-write ordering.

---
 rtl/vram_arb_pkg.sv | 18 +
 rtl/vram_wq_fifo.sv | 53 +++++
 rtl/vram_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_vram_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM port arbiter: read-return owner tags and fill FSM states.
package vram_arb_pkg;

  localparam int READ_LAT = 2;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_SCAN,
    OWN_CPU
  } owner_t;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_RUN,
    FILL_DONE
  } fill_state_t;

endpackage

// File: rtl/vram_wq_fifo.sv
// CPU write queue: synchronous FIFO, head visible combinationally, no latency beyond one push cycle.
// Backpressure: full_o blocks pushes; pops on an empty queue are ignored.
module vram_wq_fifo #(
  parameter int WIDTH = 46,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_dat_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_dat_o = mem_q[rd_ptr_q[PW-1:0]];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_dat_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/vram_port_arbiter.sv
// Arbitrates one SDP video RAM between scan reads, CPU reads/writes and a fill engine; reads return 2 cycles after ack.
// Backpressure: reads held until acked (scan first, CPU after drain or starvation), writes valid/ready via the queue.
module vram_port_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int WQ_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_req,
  input  logic [ADDR_WIDTH-1:0] scan_addr,
  output logic                  scan_ack,
  output logic                  scan_rvalid,
  output logic [31:0]           scan_rdata,
  input  logic                  cpu_rd_req,
  input  logic [ADDR_WIDTH-1:0] cpu_rd_addr,
  output logic                  cpu_rd_ack,
  output logic                  cpu_rvalid,
  output logic [31:0]           cpu_rdata,
  input  logic                  cpu_wr_req,
  input  logic [ADDR_WIDTH-1:0] cpu_wr_addr,
  input  logic [31:0]           cpu_wr_data,
  input  logic [3:0]            cpu_wr_be,
  output logic                  cpu_wr_ready,
  input  logic                  fill_start,
  input  logic [ADDR_WIDTH-1:0] fill_base,
  input  logic [ADDR_WIDTH:0]   fill_count,
  input  logic [31:0]           fill_value,
  output logic                  fill_busy,
  output logic                  fill_done,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [31:0]           ram_write_data,
  output logic                  ram_write_enable,
  output logic [3:0]            ram_byte_enable,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic                  ram_read_enable,
  input  logic [31:0]           ram_read_data
);

  localparam int AW  = ADDR_WIDTH;
  localparam int WQW = ADDR_WIDTH + 36;
  localparam int SW  = $clog2(STARVE_LIMIT + 1);

  logic           wq_full, wq_empty;
  logic [WQW-1:0] wq_head;
  logic [AW-1:0]  wq_addr;
  logic [31:0]    wq_data;
  logic [3:0]     wq_be;

  assign cpu_wr_ready = !wq_full;
  assign {wq_addr, wq_data, wq_be} = wq_head;

  vram_wq_fifo #(.WIDTH(WQW), .DEPTH(WQ_DEPTH)) u_wq (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (cpu_wr_req),
    .push_dat_i ({cpu_wr_addr, cpu_wr_data, cpu_wr_be}),
    .pop_i      (!wq_empty),
    .head_dat_o (wq_head),
    .full_o     (wq_full),
    .empty_o    (wq_empty)
  );

  fill_state_t  fill_state_q, fill_state_d;
  logic [AW-1:0] fill_addr_q, fill_addr_d;
  logic [AW:0]   fill_cnt_q, fill_cnt_d;
  logic [31:0]   fill_val_q, fill_val_d;
  logic          fill_wr;

  // Fill only writes in cycles the CPU queue leaves the write port free.
  always_comb begin
    fill_state_d = fill_state_q;
    fill_addr_d  = fill_addr_q;
    fill_cnt_d   = fill_cnt_q;
    fill_val_d   = fill_val_q;
    fill_wr      = 1'b0;
    fill_busy    = (fill_state_q == FILL_RUN);
    fill_done    = (fill_state_q == FILL_DONE);
    case (fill_state_q)
      FILL_IDLE: if (fill_start) begin
        fill_addr_d  = fill_base;
        fill_cnt_d   = fill_count;
        fill_val_d   = fill_value;
        fill_state_d = (fill_count == '0) ? FILL_DONE : FILL_RUN;
      end
      FILL_RUN: if (wq_empty) begin
        fill_wr     = 1'b1;
        fill_addr_d = fill_addr_q + AW'(1);
        fill_cnt_d  = fill_cnt_q - (AW+1)'(1);
        if (fill_cnt_q == (AW+1)'(1)) fill_state_d = FILL_DONE;
      end
      default: fill_state_d = FILL_IDLE;
    endcase
  end

  always_comb begin
    ram_write_enable = !wq_empty || fill_wr;
    ram_write_addr   = '0;
    ram_write_data   = '0;
    ram_byte_enable  = '0;
    if (!wq_empty) begin
      ram_write_addr  = wq_addr;
      ram_write_data  = wq_data;
      ram_byte_enable = wq_be;
    end else if (fill_wr) begin
      ram_write_addr  = fill_addr_q;
      ram_write_data  = fill_val_q;
      ram_byte_enable = 4'hF;
    end
  end

  logic [SW-1:0] starve_q, starve_d;
  logic          starved, cpu_ok;
  owner_t        own_q [READ_LAT];
  owner_t        own_in;

  // CPU reads wait for the write queue to drain, which keeps read-after-write ordering.
  assign starved    = (starve_q == SW'(STARVE_LIMIT));
  assign cpu_ok     = cpu_rd_req && wq_empty && !fill_busy;
  assign cpu_rd_ack = cpu_ok && (!scan_req || starved);
  assign scan_ack   = scan_req && !cpu_rd_ack;

  assign ram_read_enable = scan_ack || cpu_rd_ack;
  assign ram_read_addr   = cpu_rd_ack ? cpu_rd_addr : (scan_ack ? scan_addr : '0);
  assign own_in          = cpu_rd_ack ? OWN_CPU : (scan_ack ? OWN_SCAN : OWN_NONE);

  always_comb begin
    starve_d = starve_q;
    if (cpu_rd_ack)                 starve_d = '0;
    else if (cpu_rd_req && !starved) starve_d = starve_q + SW'(1);
  end

  assign scan_rvalid = (own_q[READ_LAT-1] == OWN_SCAN);
  assign cpu_rvalid  = (own_q[READ_LAT-1] == OWN_CPU);
  assign scan_rdata  = scan_rvalid ? ram_read_data : '0;
  assign cpu_rdata   = cpu_rvalid ? ram_read_data : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_state_q <= FILL_IDLE;
      fill_addr_q  <= '0;
      fill_cnt_q   <= '0;
      fill_val_q   <= '0;
      starve_q     <= '0;
      for (int i = 0; i < READ_LAT; i++) own_q[i] <= OWN_NONE;
    end else begin
      fill_state_q <= fill_state_d;
      fill_addr_q  <= fill_addr_d;
      fill_cnt_q   <= fill_cnt_d;
      fill_val_q   <= fill_val_d;
      starve_q     <= starve_d;
      own_q[0]     <= own_in;
      for (int i = 1; i < READ_LAT; i++) own_q[i] <= own_q[i-1];
    end
  end

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a 2-cycle-latency RAM model.
module tb_vram_port_arbiter;

  logic        clk, rst_n;
  logic        scan_req, scan_ack, scan_rvalid;
  logic [9:0]  scan_addr;
  logic [31:0] scan_rdata;
  logic        cpu_rd_req, cpu_rd_ack, cpu_rvalid;
  logic [9:0]  cpu_rd_addr;
  logic [31:0] cpu_rdata;
  logic        cpu_wr_req, cpu_wr_ready;
  logic [9:0]  cpu_wr_addr;
  logic [31:0] cpu_wr_data;
  logic [3:0]  cpu_wr_be;
  logic        fill_start, fill_busy, fill_done;
  logic [9:0]  fill_base;
  logic [10:0] fill_count;
  logic [31:0] fill_value;
  logic [9:0]  ram_write_addr, ram_read_addr;
  logic [31:0] ram_write_data, ram_read_data;
  logic        ram_write_enable, ram_read_enable;
  logic [3:0]  ram_byte_enable;

  logic        bd_we;
  logic [9:0]  bd_addr;
  logic [31:0] bd_data;
  logic [31:0] mem [0:1023];
  logic [31:0] rd_s1, rd_s2;
  int          done_cnt;
  int          checks = 0;
  int          errors = 0;

  vram_port_arbiter #(.ADDR_WIDTH(10), .WQ_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .scan_req(scan_req), .scan_addr(scan_addr), .scan_ack(scan_ack),
    .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
    .cpu_rd_req(cpu_rd_req), .cpu_rd_addr(cpu_rd_addr), .cpu_rd_ack(cpu_rd_ack),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .cpu_wr_req(cpu_wr_req), .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_wr_be(cpu_wr_be), .cpu_wr_ready(cpu_wr_ready),
    .fill_start(fill_start), .fill_base(fill_base), .fill_count(fill_count),
    .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
    .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
    .ram_write_enable(ram_write_enable), .ram_byte_enable(ram_byte_enable),
    .ram_read_addr(ram_read_addr), .ram_read_enable(ram_read_enable),
    .ram_read_data(ram_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: byte-enabled writes, two-stage read pipeline, plus a preload port.
  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    if (ram_write_enable)
      for (int b = 0; b < 4; b++)
        if (ram_byte_enable[b]) mem[ram_write_addr][8*b +: 8] <= ram_write_data[8*b +: 8];
    if (ram_read_enable) rd_s1 <= mem[ram_read_addr];
    rd_s2 <= rd_s1;
  end
  assign ram_read_data = rd_s2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_cnt <= done_cnt;
    else if (fill_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic check_reset();
    check("rst_scan_ack", 32'(scan_ack), 0);
    check("rst_scan_rvalid", 32'(scan_rvalid), 0);
    check("rst_scan_rdata", scan_rdata, 0);
    check("rst_cpu_rd_ack", 32'(cpu_rd_ack), 0);
    check("rst_cpu_rvalid", 32'(cpu_rvalid), 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_wr_ready", 32'(cpu_wr_ready), 1);
    check("rst_fill_busy", 32'(fill_busy), 0);
    check("rst_fill_done", 32'(fill_done), 0);
    check("rst_ram_we", 32'(ram_write_enable), 0);
    check("rst_ram_waddr", 32'(ram_write_addr), 0);
    check("rst_ram_wdata", ram_write_data, 0);
    check("rst_ram_be", 32'(ram_byte_enable), 0);
    check("rst_ram_re", 32'(ram_read_enable), 0);
    check("rst_ram_raddr", 32'(ram_read_addr), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  logic [9:0]  pa [8];
  logic [31:0] pd [8];

  initial begin
    done_cnt = 0;
    rst_n = 1'b0;
    scan_req = 0; scan_addr = '0;
    cpu_rd_req = 0; cpu_rd_addr = '0;
    cpu_wr_req = 0; cpu_wr_addr = '0; cpu_wr_data = '0; cpu_wr_be = '0;
    fill_start = 0; fill_base = '0; fill_count = '0; fill_value = '0;
    bd_we = 0; bd_addr = '0; bd_data = '0;
    pa = '{10'h010, 10'h040, 10'h020, 10'h3FE, 10'h3FF, 10'h000, 10'h001, 10'h002};
    pd = '{32'h12345678, 32'hCAFEF00D, 32'h0BADF00D, 32'hFFFFFFFF,
           32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5A5A5A5A};

    repeat (2) @(posedge clk);
    smp(); check_reset();
    nxt(); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bd_we = 1; bd_addr = pa[i]; bd_data = pd[i];
      nxt();
    end
    bd_we = 0;
    nxt();

    // Scan read: same-cycle ack, data two cycles later.
    scan_req = 1; scan_addr = 10'h010;
    smp();
    check("scan_ack", 32'(scan_ack), 1);
    check("scan_re", 32'(ram_read_enable), 1);
    check("scan_raddr", 32'(ram_read_addr), 32'h010);
    nxt(); scan_req = 0;
    smp(); check("scan_rvalid_t1", 32'(scan_rvalid), 0);
    nxt();
    smp();
    check("scan_rvalid_t2", 32'(scan_rvalid), 1);
    check("scan_rdata", scan_rdata, 32'h12345678);
    check("scan_cpu_rvalid", 32'(cpu_rvalid), 0);
    nxt();

    // Starvation: CPU denied 8 cycles under constant scan, wins the 9th.
    scan_req = 1; scan_addr = 10'h010; cpu_rd_req = 1; cpu_rd_addr = 10'h040;
    for (int k = 0; k < 8; k++) begin
      smp(); check("starve_deny", 32'(cpu_rd_ack), 0);
      nxt();
    end
    smp();
    check("starve_grant", 32'(cpu_rd_ack), 1);
    check("starve_scan_held", 32'(scan_ack), 0);
    check("starve_raddr", 32'(ram_read_addr), 32'h040);
    nxt(); cpu_rd_req = 0;
    smp();
    check("starve_scan_resume", 32'(scan_ack), 1);
    check("starve_scan_rv", 32'(scan_rvalid), 1);
    nxt();
    smp();
    check("starve_cpu_rv", 32'(cpu_rvalid), 1);
    check("starve_cpu_rdata", cpu_rdata, 32'hCAFEF00D);
    check("starve_scan_rv_gap", 32'(scan_rvalid), 0);
    nxt(); scan_req = 0;
    smp();
    check("starve_scan_rv2", 32'(scan_rvalid), 1);
    check("starve_scan_rdata2", scan_rdata, 32'h12345678);
    nxt(); nxt();

    // Five back-to-back writes: each lands the cycle after it is pushed.
    for (int k = 0; k < 5; k++) begin
      cpu_wr_req = 1; cpu_wr_addr = 10'(10'h100 + k);
      cpu_wr_data = 32'h11111111 * (k + 1); cpu_wr_be = 4'hF;
      smp();
      check("wr_ready", 32'(cpu_wr_ready), 1);
      if (k > 0) begin
        check("wr_order_addr", 32'(ram_write_addr), 32'h100 + k - 1);
        check("wr_order_data", ram_write_data, 32'h11111111 * k);
      end
      nxt();
    end
    cpu_wr_req = 0;
    smp();
    check("wr_last_addr", 32'(ram_write_addr), 32'h104);
    check("wr_last_data", ram_write_data, 32'h55555555);
    nxt();
    cpu_wr_req = 1; cpu_wr_addr = 10'h102; cpu_wr_data = 32'hAAAA5555; cpu_wr_be = 4'b0011;
    nxt(); cpu_wr_req = 0;
    smp(); check("wr_be_port", 32'(ram_byte_enable), 32'h3);
    nxt();
    smp();
    check("wr_be_mem", mem[10'h102], 32'h33335555);
    check("wr_mem_first", mem[10'h100], 32'h11111111);
    check("wr_mem_last", mem[10'h104], 32'h55555555);
    nxt();

    // Read-after-write: read held off until the queue drains.
    cpu_wr_req = 1; cpu_wr_addr = 10'h020; cpu_wr_data = 32'hDEADBEEF; cpu_wr_be = 4'hF;
    nxt();
    cpu_wr_req = 0; cpu_rd_req = 1; cpu_rd_addr = 10'h020;
    smp();
    check("raw_ack_held", 32'(cpu_rd_ack), 0);
    check("raw_wr_port", 32'(ram_write_enable), 1);
    nxt();
    smp(); check("raw_ack", 32'(cpu_rd_ack), 1);
    nxt(); cpu_rd_req = 0;
    nxt();
    smp();
    check("raw_rvalid", 32'(cpu_rvalid), 1);
    check("raw_rdata", cpu_rdata, 32'hDEADBEEF);
    nxt();

    // Fill with wrap-around; a CPU write steals one slot; a second start is ignored.
    fill_start = 1; fill_base = 10'h3FE; fill_count = 11'd4; fill_value = 32'h0;
    smp(); check("fill_busy_start", 32'(fill_busy), 0);
    nxt();
    fill_base = 10'h200; fill_count = 11'd2; fill_value = 32'hFFFF0000;
    smp();
    check("fill_busy", 32'(fill_busy), 1);
    check("fill_w0_addr", 32'(ram_write_addr), 32'h3FE);
    check("fill_w0_data", ram_write_data, 32'h0);
    check("fill_w0_be", 32'(ram_byte_enable), 32'hF);
    nxt();
    fill_start = 0;
    cpu_wr_req = 1; cpu_wr_addr = 10'h050; cpu_wr_data = 32'h77777777; cpu_wr_be = 4'hF;
    smp(); check("fill_w1_addr", 32'(ram_write_addr), 32'h3FF);
    nxt(); cpu_wr_req = 0;
    smp();
    check("fill_cpu_prio_addr", 32'(ram_write_addr), 32'h050);
    check("fill_cpu_prio_data", ram_write_data, 32'h77777777);
    nxt();
    smp(); check("fill_wrap_addr", 32'(ram_write_addr), 32'h000);
    nxt();
    smp(); check("fill_w3_addr", 32'(ram_write_addr), 32'h001);
    nxt();
    smp();
    check("fill_done", 32'(fill_done), 1);
    check("fill_done_busy", 32'(fill_busy), 0);
    check("fill_done_we", 32'(ram_write_enable), 0);
    nxt();
    smp();
    check("fill_done_pulse", 32'(fill_done), 0);
    check("fill_done_count", done_cnt, 1);
    check("fill_mem_3fe", mem[10'h3FE], 0);
    check("fill_mem_3ff", mem[10'h3FF], 0);
    check("fill_mem_000", mem[10'h000], 0);
    check("fill_mem_001", mem[10'h001], 0);
    check("fill_mem_002", mem[10'h002], 32'h5A5A5A5A);
    nxt();

    // Zero-length fill: done pulse with no writes.
    fill_start = 1; fill_base = 10'h123; fill_count = 11'd0; fill_value = 32'h99999999;
    nxt(); fill_start = 0;
    smp();
    check("fill0_done", 32'(fill_done), 1);
    check("fill0_we", 32'(ram_write_enable), 0);
    check("fill0_busy", 32'(fill_busy), 0);
    nxt();
    smp();
    check("fill0_pulse", 32'(fill_done), 0);
    check("fill0_count", done_cnt, 2);
    nxt();

    // Reset mid-fill with a scan read in flight.
    fill_start = 1; fill_base = 10'h300; fill_count = 11'd8; fill_value = 32'h0;
    nxt(); fill_start = 0; scan_req = 1; scan_addr = 10'h010;
    smp();
    check("rst_mid_busy", 32'(fill_busy), 1);
    check("rst_mid_scan_ack", 32'(scan_ack), 1);
    nxt(); scan_req = 0; rst_n = 1'b0;
    smp(); check_reset();
    nxt();
    smp(); check("rst_mid_no_rvalid", 32'(scan_rvalid), 0);
    nxt(); rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      smp();
      check("rst_post_busy", 32'(fill_busy), 0);
      check("rst_post_rvalid", 32'(scan_rvalid), 0);
      nxt();
    end
    check("rst_post_done_count", done_cnt, 2);
    check("rst_post_wr_ready", 32'(cpu_wr_ready), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
